// File: rtl/core_pkg.sv
// Shared core definitions: opcode encoding, default widths and the memory-stage state type.
// Used by decode, execute and the memory stage.
package core_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;
  localparam int IDX_W  = 5;
  localparam int TGT_W  = 14;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_AND   = 4'd3;
  localparam logic [3:0] OP_OR    = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_NOT   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_SHR   = 4'd8;
  localparam logic [3:0] OP_CMP   = 4'd9;
  localparam logic [3:0] OP_JUMP  = 4'd10;
  localparam logic [3:0] OP_BEQ   = 4'd11;
  localparam logic [3:0] OP_BNE   = 4'd12;
  localparam logic [3:0] OP_LOAD  = 4'd13;
  localparam logic [3:0] OP_STORE = 4'd14;
  localparam logic [3:0] OP_MOV   = 4'd15;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_e;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory req/ack handshake: IDLE/WAIT state, request registers and stall generation.
// Request fields are captured on entry to WAIT and held until the ack cycle.
module mem_handshake_fsm
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int ADDR_W = core_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_is_mem,
  input  logic              i_is_store,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_mem_ack,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_stall,
  output logic              o_busy,
  output logic              o_capture,
  output logic              o_done
);

  mem_state_e r_state;
  mem_state_e w_next_state;

  // NOTE: every output of this block is defaulted first so no path leaves one unassigned, which would infer a latch.
  always_comb begin
    w_next_state = r_state;
    o_stall      = 1'b0;
    o_capture    = 1'b0;
    o_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_is_mem) begin
          o_stall      = 1'b1;
          o_capture    = 1'b1;
          w_next_state = ST_WAIT;
        end
      end
      ST_WAIT: begin
        o_stall = !i_mem_ack;
        if (i_mem_ack) begin
          o_done       = 1'b1;
          w_next_state = ST_IDLE;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  assign o_busy = (r_state == ST_WAIT);

  // NOTE: sequential state uses non-blocking assignments so all registers update together from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (o_capture) begin
        o_mem_req   <= 1'b1;
        o_mem_we    <= i_is_store;
        o_mem_addr  <= i_addr;
        o_mem_wdata <= i_wdata;
      end else if (o_done) begin
        o_mem_req <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues LOAD/STORE through the handshake FSM and registers the
// writeback bundle and branch target with one cycle of latency.
module mem_stage
  import core_pkg::*;
#(
  parameter int DATA_W = core_pkg::DATA_W,
  parameter int ADDR_W = core_pkg::ADDR_W,
  parameter int IDX_W  = core_pkg::IDX_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        control_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] reg2_in,
  input  logic [IDX_W-1:0]  dest_index_in,
  input  logic              write_en_in,
  input  logic [13:0]       target_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              wb_en,
  output logic [IDX_W-1:0]  wb_index,
  output logic [DATA_W-1:0] wb_data,
  output logic [13:0]       target_out
);

  logic w_is_mem;
  logic w_is_store;
  logic w_busy;
  logic w_capture;
  logic w_done;
  logic w_pass;

  logic             r_is_load;
  logic [IDX_W-1:0] r_dest_index;

  assign w_is_mem   = is_mem_op(control_in);
  assign w_is_store = (control_in == OP_STORE);
  assign w_pass     = !w_busy && !w_is_mem;

  mem_handshake_fsm #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_fsm (
    .clk         (clk),
    .rst         (rst),
    .i_is_mem    (w_is_mem),
    .i_is_store  (w_is_store),
    .i_addr      (reg2_in[ADDR_W-1:0]),
    .i_wdata     (alu_result_in),
    .i_mem_ack   (mem_ack),
    .o_mem_req   (mem_req),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .o_stall     (stall),
    .o_busy      (w_busy),
    .o_capture   (w_capture),
    .o_done      (w_done)
  );

  // wb_en defaults to a bubble each cycle so it can only ever pulse for one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_en        <= 1'b0;
      wb_index     <= '0;
      wb_data      <= '0;
      target_out   <= '0;
      r_is_load    <= 1'b0;
      r_dest_index <= '0;
    end else begin
      wb_en <= 1'b0;
      if (w_pass) begin
        wb_en      <= write_en_in;
        wb_index   <= dest_index_in;
        wb_data    <= alu_result_in;
        target_out <= target_in;
      end else if (w_capture) begin
        r_is_load    <= (control_in == OP_LOAD);
        r_dest_index <= dest_index_in;
        target_out   <= '0;
      end else if (w_done && r_is_load) begin
        wb_en    <= 1'b1;
        wb_index <= r_dest_index;
        wb_data  <= mem_rdata;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 16-bit pipelined core; consumes the registered outputs of the execute stage and produces the writeback bundle for the register file.
- Issues LOAD/STORE to data memory over a req/ack handshake.
- Stalls upstream stages while an access is outstanding.
- Passes ALU results and branch targets through with one cycle of latency.

Parameters:
- DATA_W, 16, datapath width.
- ADDR_W, 14, data-memory address width; the address is the low ADDR_W bits of reg2_in.
- IDX_W, 5, register index width.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- control_in  in  4  opcode from execute (NOP=0 … STORE=14, MOV=15)
- alu_result_in  in  DATA_W  execute result; for STORE this is the store data (reg1)
- reg2_in  in  DATA_W  execute reg2 value; for LOAD/STORE this is the address
- dest_index_in  in  IDX_W  destination register index
- write_en_in  in  1  execute's destination write enable
- target_in  in  14  branch/jump target from execute, 0 = none
- mem_req  out  1  memory request, held until ack
- mem_we  out  1  1 = write (STORE), 0 = read (LOAD)
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
- mem_ack  in  1  single-cycle access completion
- stall  out  1  combinational; upstream stages hold while high
- wb_en  out  1  register-file write enable
- wb_index  out  IDX_W  writeback register index
- wb_data  out  DATA_W  writeback data
- target_out  out  14  registered target, 0 when no redirect

Behaviour:
- Reset values: all registered outputs are 0 (mem_req, mem_we, mem_addr, mem_wdata, wb_en, wb_index, wb_data, target_out). State is IDLE.
- Reset is asynchronous and overrides everything, including mid-WAIT. An ack arriving after reset is ignored.
- is_mem = (control_in == LOAD) || (control_in == STORE).
- FSM states: IDLE, WAIT.
- IDLE with !is_mem:
  - At the edge: wb_en<=write_en_in, wb_index<=dest_index_in, wb_data<=alu_result_in, target_out<=target_in.
  - Latency is exactly 1 cycle. NOP and CMP arrive with write_en_in=0, so they produce wb_en=0.
- IDLE with is_mem:
  - stall=1 in this cycle.
  - At the edge: mem_req<=1, mem_we<=(STORE), mem_addr<=reg2_in[ADDR_W-1:0], mem_wdata<=alu_result_in.
  - Latch dest_index_in and the LOAD flag; wb_en<=0, target_out<=0; go to WAIT.
- WAIT:
  - Inputs are ignored; stall = !mem_ack.
  - mem_req/mem_we/mem_addr/mem_wdata are held stable until ack.
  - On mem_ack, at the edge: mem_req<=0 and state<=IDLE.
  - LOAD completion: wb_en<=1, wb_index<=latched index, wb_data<=mem_rdata.
  - STORE completion: wb_en<=0.
  - Without ack: wb_en<=0 (bubble).
- Minimum LOAD latency: capture edge, then ack in the first WAIT cycle, giving wb_en 2 cycles after the LOAD is presented.
- mem_ack in IDLE is ignored.
- Back-to-back memory ops: the next LOAD/STORE is presented in the cycle after ack and follows the IDLE→WAIT path again. There are no dead cycles beyond the capture cycle.
- wb_en is a single-cycle pulse per instruction; wb_data is don't-care when wb_en=0 but holds its last value.
- Undefined opcodes are treated as non-memory and pass through write_en_in.

Decomposition:
- Shared package core_pkg holds the opcode localparams (NOP…MOV, 4-bit) and DATA_W/IDX_W defaults, also used by decode/execute.
- One natural sub-module, mem_handshake_fsm: the IDLE/WAIT state, the request registers and the stall logic. mem_stage wraps it together with the writeback/target pipeline registers.

Test Plan:
- Reset mid-WAIT: issue a LOAD, assert rst in WAIT before ack → mem_req=0 and all outputs 0 immediately. A later mem_ack=1 produces no wb_en.
- ADD pass-through: control_in=ADD, alu_result_in=0x1234, dest=3, write_en_in=1, target_in=0 → next cycle wb_en=1, wb_index=3, wb_data=0x1234, stall never high.
- LOAD with 3-cycle memory: control_in=LOAD, reg2_in=0x0040, dest=7 → stall=1 in that cycle; mem_req=1, mem_we=0, mem_addr=0x0040. Ack in the 3rd WAIT cycle with mem_rdata=0xBEEF → stall low in the ack cycle; next cycle wb_en=1, wb_index=7, wb_data=0xBEEF, mem_req=0.
- STORE then LOAD back-to-back: STORE alu_result_in=0x00AA, reg2_in=0x0010, ack after 1 cycle; then LOAD from 0x0010 → mem_we=1 with mem_wdata=0x00AA for the first access, and wb_en=0 for it. Second request appears the cycle after the LOAD is presented; returned 0x00AA is written back.
- Spurious ack and target pass-through: mem_ack=1 while IDLE with control_in=JUMP, target_in=0x0123 → no mem_req, target_out=0x0123 next cycle, wb_en=0.
